// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: grant state encoding,
// owner identifiers and the byte/half/word alignment rule also used by the
// processor memory stage.
package dmem_arbiter_pkg;

    // Grant state of the shared dmem port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Identifies which requester held the port most recently.
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Alignment rule on the two low address bits (addr_lo[1] is the bit of
    // weight 2, addr_lo[0] the bit of weight 1).
    //   byte            -> always aligned
    //   half            -> bit of weight 1 must be 0
    //   word            -> both low bits must be 0
    //   byte and half   -> illegal size code, treated as misaligned
    function automatic logic size_aligned(
        input logic [1:0] addr_lo,
        input logic       is_byte,
        input logic       is_half
    );
        logic ok;
        ok = 1'b0;
        if (is_byte && is_half) begin
            ok = 1'b0;
        end else if (is_byte) begin
            ok = 1'b1;
        end else if (is_half) begin
            ok = ~addr_lo[0];
        end else begin
            ok = (addr_lo == 2'b00);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Combinational alignment check: low address bits plus access size in,
// aligned flag out.
module dmem_align_check
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] i_addr_lo,
    input  logic       i_byte,
    input  logic       i_half,
    output logic       o_aligned
);

    assign o_aligned = size_aligned(i_addr_lo, i_byte, i_half);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port. m0 is the processor
// load/store path, m1 the debug/DMA loader. Grants come from a registered
// state machine with round-robin tie breaking and a burst limit that hands
// the port over when the other side has waited MAX_BURST owned cycles.
// Memory-side outputs are combinational muxes of the current owner's fields;
// misaligned accesses have their write suppressed and raise align_err one
// cycle later.
//
// Handshake: a requester raises req together with stable we/size/addr/wdata
// and holds them until it observes its gnt; a granted cycle with req high is
// the transfer cycle. Grant is decoded from registered state, so the earliest
// grant is the cycle after req rises. A requester that loses gnt because of
// the burst limit keeps req asserted and is re-granted later.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_byte,
    input  logic        m0_half,
    input  logic        m0_sext,
    input  logic [0:31] m0_addr,
    input  logic [0:31] m0_wdata,
    output logic        m0_gnt,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_byte,
    input  logic        m1_half,
    input  logic        m1_sext,
    input  logic [0:31] m1_addr,
    input  logic [0:31] m1_wdata,
    output logic        m1_gnt,

    output logic [0:31] rdata,

    output logic [0:31] addr_to_mem,
    output logic        write_enable_to_mem,
    output logic        byte_to_mem,
    output logic        half_word_to_mem,
    output logic        sign_extend_to_mem,
    output logic [0:31] data_to_mem,
    input  logic [0:31] data_from_mem,

    output logic        align_err,
    output arb_state_t  o_dbg_state
);

    // Counter value on which the current owner must yield to a waiting peer.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_last;
    logic             r_align_err;

    logic             w_own_req;
    logic             w_own_we;
    logic             w_own_byte;
    logic             w_own_half;
    logic             w_own_sext;
    logic [0:31]      w_own_addr;
    logic [0:31]      w_own_wdata;
    logic             w_aligned;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturating increment so a held contention can never wrap the counter.
    assign w_cnt_inc = (r_burst_cnt == {CNT_W{1'b1}}) ? r_burst_cnt
                                                      : r_burst_cnt + 1'b1;

    // Select the owner's request fields; everything is zero while idle.
    always_comb begin
        w_own_req   = 1'b0;
        w_own_we    = 1'b0;
        w_own_byte  = 1'b0;
        w_own_half  = 1'b0;
        w_own_sext  = 1'b0;
        w_own_addr  = '0;
        w_own_wdata = '0;
        case (r_state)
            ST_OWN0: begin
                w_own_req   = m0_req;
                w_own_we    = m0_we;
                w_own_byte  = m0_byte;
                w_own_half  = m0_half;
                w_own_sext  = m0_sext;
                w_own_addr  = m0_addr;
                w_own_wdata = m0_wdata;
            end
            ST_OWN1: begin
                w_own_req   = m1_req;
                w_own_we    = m1_we;
                w_own_byte  = m1_byte;
                w_own_half  = m1_half;
                w_own_sext  = m1_sext;
                w_own_addr  = m1_addr;
                w_own_wdata = m1_wdata;
            end
            default: begin
                w_own_req = 1'b0;
            end
        endcase
    end

    dmem_align_check u_align (
        .i_addr_lo (w_own_addr[30:31]),
        .i_byte    (w_own_byte),
        .i_half    (w_own_half),
        .o_aligned (w_aligned)
    );

    // Grant FSM: owner tracking, round-robin history, burst limit and the
    // registered misalignment pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
            r_last      <= OWNER_M1;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_own_req & ~w_aligned;
            case (r_state)
                ST_IDLE: begin
                    r_burst_cnt <= '0;
                    if (m0_req && m1_req) begin
                        r_state <= (r_last == OWNER_M0) ? ST_OWN1 : ST_OWN0;
                    end else if (m0_req) begin
                        r_state <= ST_OWN0;
                    end else if (m1_req) begin
                        r_state <= ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    if (!m0_req) begin
                        r_last      <= OWNER_M0;
                        r_burst_cnt <= '0;
                        r_state     <= m1_req ? ST_OWN1 : ST_IDLE;
                    end else if (m1_req && (r_burst_cnt == BURST_LAST)) begin
                        r_last      <= OWNER_M0;
                        r_burst_cnt <= '0;
                        r_state     <= ST_OWN1;
                    end else if (m1_req) begin
                        r_burst_cnt <= w_cnt_inc;
                    end else begin
                        r_burst_cnt <= '0;
                    end
                end
                ST_OWN1: begin
                    if (!m1_req) begin
                        r_last      <= OWNER_M1;
                        r_burst_cnt <= '0;
                        r_state     <= m0_req ? ST_OWN0 : ST_IDLE;
                    end else if (m0_req && (r_burst_cnt == BURST_LAST)) begin
                        r_last      <= OWNER_M1;
                        r_burst_cnt <= '0;
                        r_state     <= ST_OWN0;
                    end else if (m0_req) begin
                        r_burst_cnt <= w_cnt_inc;
                    end else begin
                        r_burst_cnt <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    assign m0_gnt              = (r_state == ST_OWN0);
    assign m1_gnt              = (r_state == ST_OWN1);
    assign o_dbg_state         = r_state;
    assign align_err           = r_align_err;

    assign addr_to_mem         = w_own_addr;
    assign data_to_mem         = w_own_wdata;
    assign byte_to_mem         = w_own_byte;
    assign half_word_to_mem    = w_own_half;
    assign sign_extend_to_mem  = w_own_sext;
    assign write_enable_to_mem = w_own_req & w_own_we & w_aligned;

    assign rdata               = data_from_mem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small big-endian byte memory model
// standing in for dmem.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m0_byte, m0_half, m0_sext;
    logic [0:31] m0_addr, m0_wdata;
    logic        m0_gnt;
    logic        m1_req, m1_we, m1_byte, m1_half, m1_sext;
    logic [0:31] m1_addr, m1_wdata;
    logic        m1_gnt;
    logic [0:31] rdata;
    logic [0:31] addr_to_mem;
    logic        write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem;
    logic [0:31] data_to_mem;
    logic [0:31] data_from_mem;
    logic        align_err;
    arb_state_t  dbg_state;

    int checks;
    int errors;

    dmem_arbiter #(.MAX_BURST(8), .CNT_W(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .m0_req              (m0_req),
        .m0_we               (m0_we),
        .m0_byte             (m0_byte),
        .m0_half             (m0_half),
        .m0_sext             (m0_sext),
        .m0_addr             (m0_addr),
        .m0_wdata            (m0_wdata),
        .m0_gnt              (m0_gnt),
        .m1_req              (m1_req),
        .m1_we               (m1_we),
        .m1_byte             (m1_byte),
        .m1_half             (m1_half),
        .m1_sext             (m1_sext),
        .m1_addr             (m1_addr),
        .m1_wdata            (m1_wdata),
        .m1_gnt              (m1_gnt),
        .rdata               (rdata),
        .addr_to_mem         (addr_to_mem),
        .write_enable_to_mem (write_enable_to_mem),
        .byte_to_mem         (byte_to_mem),
        .half_word_to_mem    (half_word_to_mem),
        .sign_extend_to_mem  (sign_extend_to_mem),
        .data_to_mem         (data_to_mem),
        .data_from_mem       (data_from_mem),
        .align_err           (align_err),
        .o_dbg_state         (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- dmem model ----------------
    logic [7:0] mem [0:255];
    logic [7:0] mem_a;
    assign mem_a = addr_to_mem[24:31];

    always_comb begin
        data_from_mem = {mem[{mem_a[7:2], 2'b00}], mem[{mem_a[7:2], 2'b01}],
                         mem[{mem_a[7:2], 2'b10}], mem[{mem_a[7:2], 2'b11}]};
    end

    always @(posedge clock) begin
        if (!reset && write_enable_to_mem) begin
            if (byte_to_mem) begin
                mem[mem_a] <= data_to_mem[24:31];
            end else if (half_word_to_mem) begin
                mem[mem_a]        <= data_to_mem[16:23];
                mem[mem_a + 8'd1] <= data_to_mem[24:31];
            end else begin
                mem[{mem_a[7:2], 2'b00}] <= data_to_mem[0:7];
                mem[{mem_a[7:2], 2'b01}] <= data_to_mem[8:15];
                mem[{mem_a[7:2], 2'b10}] <= data_to_mem[16:23];
                mem[{mem_a[7:2], 2'b11}] <= data_to_mem[24:31];
            end
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_byte = 0; m0_half = 0; m0_sext = 0;
        m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_byte = 0; m1_half = 0; m1_sext = 0;
        m1_addr = '0; m1_wdata = '0;
    endtask

    // Advance to just after the next rising edge (start of a new cycle).
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Move to the middle of the current cycle for sampling.
    task automatic mid();
        @(negedge clock);
    endtask

    // Two-cycle reset; released just after a rising edge so that cycle 1
    // begins at release.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt}); end
        checks++; if (write_enable_to_mem !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", write_enable_to_mem); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b expected 0", align_err); end
        checks++; if (addr_to_mem !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", addr_to_mem); end
        checks++; if ({byte_to_mem, half_word_to_mem, sign_extend_to_mem} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {byte_to_mem, half_word_to_mem, sign_extend_to_mem}); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_first_write();
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        mid();
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL first_write_c1_gnt: got %b expected 0", m0_gnt); end
        step(); mid();
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL first_write_c2_gnt: got %b expected 1", m0_gnt); end
        checks++; if (write_enable_to_mem !== 1'b1) begin errors++; $display("FAIL first_write_we: got %b expected 1", write_enable_to_mem); end
        checks++; if (addr_to_mem !== 32'h10) begin errors++; $display("FAIL first_write_addr: got %h expected 00000010", addr_to_mem); end
        checks++; if (data_to_mem !== 32'hDEADBEEF) begin errors++; $display("FAIL first_write_data: got %h expected deadbeef", data_to_mem); end
        step();
        m0_req = 0; m0_we = 0;
        checks++; if (mem_word(32'h10) !== 32'hDEADBEEF) begin errors++; $display("FAIL first_write_mem: got %h expected deadbeef", mem_word(32'h10)); end
        step();
        m0_req = 1; m0_addr = 32'h10;
        mid();
        step(); mid();
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL readback_gnt: got %b expected 1", m0_gnt); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_rdata: got %h expected deadbeef", rdata); end
        checks++; if (write_enable_to_mem !== 1'b0) begin errors++; $display("FAIL readback_we: got %b expected 0", write_enable_to_mem); end
        step();
        clear_inputs();
    endtask

    task automatic test_tie_handoff();
        do_reset();
        m0_req = 1; m0_addr = 32'h40;
        m1_req = 1; m1_addr = 32'h44;
        mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL tie_c1: got %b expected 00", {m0_gnt, m1_gnt}); end
        step(); mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie_c2: got %b expected 10", {m0_gnt, m1_gnt}); end
        step();
        m0_req = 0;
        mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie_c3: got %b expected 10", {m0_gnt, m1_gnt}); end
        step(); mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL tie_c4: got %b expected 01", {m0_gnt, m1_gnt}); end
        checks++; if (addr_to_mem !== 32'h44) begin errors++; $display("FAIL tie_c4_addr: got %h expected 00000044", addr_to_mem); end
        step();
        clear_inputs();
    endtask

    task automatic test_burst();
        logic [1:0]  exp_gnt;
        logic [0:31] exp_addr;
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hA0A0A0A0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h24; m1_wdata = 32'hB1B1B1B1;
        mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL burst_c1: got %b expected 00", {m0_gnt, m1_gnt}); end
        for (int c = 0; c < 24; c++) begin
            step(); mid();
            exp_gnt  = (((c / 8) % 2) == 0) ? 2'b10 : 2'b01;
            exp_addr = (((c / 8) % 2) == 0) ? 32'h20 : 32'h24;
            checks++; if ({m0_gnt, m1_gnt} !== exp_gnt) begin errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", c, {m0_gnt, m1_gnt}, exp_gnt); end
            checks++; if (addr_to_mem !== exp_addr || write_enable_to_mem !== 1'b1) begin errors++; $display("FAIL burst_issue[%0d]: got addr %h we %b expected addr %h we 1", c, addr_to_mem, write_enable_to_mem, exp_addr); end
        end
        step();
        clear_inputs();
        checks++; if (mem_word(32'h20) !== 32'hA0A0A0A0) begin errors++; $display("FAIL burst_mem0: got %h expected a0a0a0a0", mem_word(32'h20)); end
        checks++; if (mem_word(32'h24) !== 32'hB1B1B1B1) begin errors++; $display("FAIL burst_mem1: got %h expected b1b1b1b1", mem_word(32'h24)); end
    endtask

    task automatic test_align();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h13; m1_wdata = 32'h11223344;
        mid();
        step(); mid();
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL align_word_gnt: got %b expected 1", m1_gnt); end
        checks++; if (write_enable_to_mem !== 1'b0) begin errors++; $display("FAIL align_word_we: got %b expected 0", write_enable_to_mem); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_err_early: got %b expected 0", align_err); end
        step();
        m1_req = 0; m1_we = 0;
        mid();
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_err_pulse: got %b expected 1", align_err); end
        step(); mid();
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_err_clear: got %b expected 0", align_err); end
        checks++; if (mem_word(32'h10) !== 32'hDEADBEEF) begin errors++; $display("FAIL align_mem_kept: got %h expected deadbeef", mem_word(32'h10)); end
        // Aligned half write into the low half of word 0x10.
        step();
        m1_req = 1; m1_we = 1; m1_half = 1; m1_addr = 32'h12; m1_wdata = 32'h00001234;
        step(); mid();
        checks++; if (write_enable_to_mem !== 1'b1 || half_word_to_mem !== 1'b1) begin errors++; $display("FAIL align_half_we: got we %b half %b expected 1 1", write_enable_to_mem, half_word_to_mem); end
        step();
        m1_req = 0; m1_we = 0; m1_half = 0;
        checks++; if (mem_word(32'h10) !== 32'hDEAD1234) begin errors++; $display("FAIL align_half_mem: got %h expected dead1234", mem_word(32'h10)); end
        // Illegal byte+half size code is blocked like a misaligned access.
        step();
        m1_req = 1; m1_we = 1; m1_byte = 1; m1_half = 1; m1_addr = 32'h10; m1_wdata = 32'hFFFFFFFF;
        step(); mid();
        checks++; if (m1_gnt !== 1'b1 || write_enable_to_mem !== 1'b0) begin errors++; $display("FAIL align_illegal_we: got gnt %b we %b expected 1 0", m1_gnt, write_enable_to_mem); end
        step();
        clear_inputs();
        mid();
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_illegal_err: got %b expected 1", align_err); end
        checks++; if (mem_word(32'h10) !== 32'hDEAD1234) begin errors++; $display("FAIL align_illegal_mem: got %h expected dead1234", mem_word(32'h10)); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'hCAFEF00D;
        step(); mid();
        checks++; if (m1_gnt !== 1'b1 || write_enable_to_mem !== 1'b1) begin errors++; $display("FAIL midrst_pre: got gnt %b we %b expected 1 1", m1_gnt, write_enable_to_mem); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL midrst_gnt: got %b expected 0", m1_gnt); end
        checks++; if (write_enable_to_mem !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", write_enable_to_mem); end
        step();
        reset = 1'b0;
        m1_we = 0; m1_addr = 32'h34;
        m0_req = 1; m0_addr = 32'h40;
        mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL midrst_after_c1: got %b expected 00", {m0_gnt, m1_gnt}); end
        step(); mid();
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL midrst_after_c2: got %b expected 10", {m0_gnt, m1_gnt}); end
        step();
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_first_write();
        test_tie_handoff();
        test_burst();
        test_align();
        test_reset_mid_burst();
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (dmem) between two requesters: m0 = processor load/store path, m1 = debug/DMA loader that fills and dumps memory while the processor is held.
- Registered grant state machine with round-robin priority on contention and a burst limit that forces handoff.
- Drives dmem address and control from the current owner. Misaligned accesses are blocked and flagged.
- Sits between processor, loader and dmem in the processor top level.

Parameters:
- MAX_BURST, 8, max consecutive granted cycles for one owner while the other requests (>=1)
- CNT_W, 4, burst counter width, must satisfy 2^CNT_W >= MAX_BURST

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- m0_req  in  1  processor requests the port
- m0_we, m0_byte, m0_half, m0_sext  in  1 each  processor access control
- m0_addr  in  [0:31]  processor byte address
- m0_wdata  in  [0:31]  processor store data
- m0_gnt  out  1  processor owns the port this cycle
- m1_req, m1_we, m1_byte, m1_half, m1_sext  in  1 each  loader request and control
- m1_addr, m1_wdata  in  [0:31]  loader address and data
- m1_gnt  out  1  loader owns the port this cycle
- rdata  out  [0:31]  dmem read data, broadcast to both; valid only for the granted requester
- addr_to_mem  out  [0:31]  to dmem addr
- write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem  out  1 each  to dmem
- data_to_mem  out  [0:31]  to dmem data_in
- data_from_mem  in  [0:31]  from dmem data_out
- align_err  out  1  registered one-cycle pulse: misaligned access was blocked

Behaviour:
- States: IDLE, OWN0, OWN1. m0_gnt = (state==OWN0) and m1_gnt = (state==OWN1), decoded from registered state. They are never both 1.
- Reset, asynchronous and at any time including mid-burst:
  - state=IDLE, burst_cnt=0, last=1 (m0 wins the first tie), align_err=0.
  - Consequently gnt=0 and write_enable_to_mem=0 immediately.
- Grant latency: a request raised in cycle N is granted at earliest in cycle N+1. The requester holds req and all fields stable until it sees gnt.
- IDLE:
  - one requester -> OWN of that requester.
  - both requesting -> OWN of the requester != last.
  - neither -> stay IDLE.
- OWNx:
  - req_x=0 -> if the other requests, go to OWN(other) with no bubble; otherwise IDLE. last=x.
  - req_x=1, other requesting, burst_cnt==MAX_BURST-1 -> OWN(other), last=x, burst_cnt=0. x loses gnt and must keep req asserted.
  - otherwise stay. burst_cnt increments only while the other requests, saturates, and clears when ownership changes or the other drops req.
- Datapath:
  - Memory outputs are combinational muxes of the owner's fields.
  - In IDLE: addr_to_mem=0, data_to_mem=0, all controls 0.
  - write_enable_to_mem = owner_req & owner_we & aligned. Writes occur only in owned cycles where req is still high.
- Alignment:
  - word (byte=0, half=0) requires addr[30:31]=00.
  - half requires addr[31]=0.
  - byte is always aligned.
  - byte=half=1 is illegal and treated as misaligned.
  - Misaligned owned cycle: write suppressed, reads still pass through, align_err=1 on the next cycle.
- rdata = data_from_mem, pass-through with no added latency.

Decomposition:
- Shared package: state encoding constants (IDLE, OWN0, OWN1) and size-encoding helpers (byte/half/word alignment rule), reused by the processor memory stage.
- One natural sub-module: dmem_align_check (combinational addr/size -> aligned).
- Arbiter FSM, burst counter and muxes stay in dmem_arbiter.

Test Plan:
- Reset held 2 cycles, then m0_req=1 with m0_we=1, addr=0x10, wdata=0xDEADBEEF:
  - cycle 1 has m0_gnt=0.
  - cycle 2 has m0_gnt=1, write_enable_to_mem=1, and dmem word 0x10 reads 0xDEADBEEF afterwards.
- Both req raised in the same cycle from reset: m0 granted first. m0 drops req after 1 cycle, then m1 is granted the next cycle with no IDLE cycle.
- Both req held continuously, MAX_BURST=8:
  - grant alternates every 8 cycles (OWN0 8 cycles, OWN1 8 cycles).
  - loser's writes are never issued.
- m1 word write to addr 0x13: write_enable_to_mem=0, align_err pulses 1 for one cycle, memory unchanged. Half write to 0x12 succeeds.
- Reset asserted mid-burst while OWN1 is writing: m1_gnt and write_enable_to_mem drop to 0 in the same cycle, no clock edge needed. After release, a simultaneous request grants m0 first.
